streamer_pattern: RTL and testbench

STREAMER_PATTERN -- requirements
Module: streamer_pattern

---
 rtl/streamer_pattern.sv | 133 +++++++++++++
 tb/tb_streamer_pattern.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/streamer_pattern.sv
// streamer_pattern
//   Arithmetic-sequence stream generator. An accepted start latches the
//   configuration and emits cfg_num_packets packets of cfg_len beats each
//   on a valid/ready stream. Each beat's data advances by +/- step after
//   every transfer. Data either restarts at the start value on each packet
//   boundary or carries on across boundaries.
//
// Ports
//   counter_clk      : clock; all logic runs on its rising edge
//   reset            : synchronous, active-high
//   start            : one-cycle run request; honoured only in IDLE
//   cfg_start_value  : data of the first beat
//   cfg_step         : per-transfer increment/decrement
//   cfg_down         : 0 = count up, 1 = count down
//   cfg_restart      : 1 = every packet restarts at cfg_start_value
//   cfg_len          : beats per packet
//   cfg_num_packets  : packets per run
//   count_data       : stream data
//   count_valid      : stream valid (high for the whole of RUN)
//   count_ready      : stream ready from the sink
//   count_last       : final beat of each packet
//   busy             : high while in RUN
//   done             : one-cycle pulse at the end of a run
//   pkt_count        : packets completed in the current or last run
module streamer_pattern #(
    parameter int DataWidth = 32,
    parameter int LenWidth  = 16
) (
    input  logic                 counter_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DataWidth-1:0] cfg_start_value,
    input  logic [DataWidth-1:0] cfg_step,
    input  logic                 cfg_down,
    input  logic                 cfg_restart,
    input  logic [LenWidth-1:0]  cfg_len,
    input  logic [LenWidth-1:0]  cfg_num_packets,
    output logic [DataWidth-1:0] count_data,
    output logic                 count_valid,
    input  logic                 count_ready,
    output logic                 count_last,
    output logic                 busy,
    output logic                 done,
    output logic [LenWidth-1:0]  pkt_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [DataWidth-1:0] start_q;
    logic [DataWidth-1:0] step_q;
    logic                 down_q;
    logic                 restart_q;
    logic [LenWidth-1:0]  len_q;
    logic [LenWidth-1:0]  num_q;
    logic [LenWidth-1:0]  beat_idx;
    logic [DataWidth-1:0] data_q;
    logic [DataWidth-1:0] data_next;
    logic                 xfer;
    logic                 last_beat;

    // Last flag is derived from the same registered beat index that
    // accompanies data_q, so data and last can never skew.
    assign last_beat   = (beat_idx == len_q - LenWidth'(1));
    assign data_next   = down_q ? (data_q - step_q) : (data_q + step_q);
    assign xfer        = (state == RUN) && count_ready;

    assign count_data  = data_q;
    assign count_valid = (state == RUN);
    assign count_last  = (state == RUN) && last_beat;
    assign busy        = (state == RUN);
    assign done        = (state == DONE);

    always_ff @(posedge counter_clk) begin
        if (reset) begin
            state     <= IDLE;
            start_q   <= '0;
            step_q    <= '0;
            down_q    <= 1'b0;
            restart_q <= 1'b0;
            len_q     <= '0;
            num_q     <= '0;
            beat_idx  <= '0;
            data_q    <= '0;
            pkt_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pkt_count <= '0;
                        if (cfg_len != '0 && cfg_num_packets != '0) begin
                            start_q   <= cfg_start_value;
                            step_q    <= cfg_step;
                            down_q    <= cfg_down;
                            restart_q <= cfg_restart;
                            len_q     <= cfg_len;
                            num_q     <= cfg_num_packets;
                            beat_idx  <= '0;
                            data_q    <= cfg_start_value;
                            state     <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (last_beat) begin
                            pkt_count <= pkt_count + LenWidth'(1);
                            beat_idx  <= '0;
                            data_q    <= restart_q ? start_q : data_next;
                            if (pkt_count + LenWidth'(1) == num_q) begin
                                state <= DONE;
                            end
                        end else begin
                            beat_idx <= beat_idx + LenWidth'(1);
                            data_q   <= data_next;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_streamer_pattern.sv
// tb_streamer_pattern
//   Scoreboard bench for streamer_pattern (DataWidth=8, LenWidth=8).
//   Each run pushes its expected beat sequence into a queue; beats are
//   popped and compared as the DUT transfers them.
module tb_streamer_pattern;

    logic       counter_clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] cfg_start_value;
    logic [7:0] cfg_step;
    logic       cfg_down;
    logic       cfg_restart;
    logic [7:0] cfg_len;
    logic [7:0] cfg_num_packets;
    logic [7:0] count_data;
    logic       count_valid;
    logic       count_ready;
    logic       count_last;
    logic       busy;
    logic       done;
    logic [7:0] pkt_count;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [8:0] exp_q[$];   // {last, data}

    always #5 counter_clk = ~counter_clk;

    streamer_pattern #(
        .DataWidth(8),
        .LenWidth (8)
    ) dut (
        .counter_clk    (counter_clk),
        .reset          (reset),
        .start          (start),
        .cfg_start_value(cfg_start_value),
        .cfg_step       (cfg_step),
        .cfg_down       (cfg_down),
        .cfg_restart    (cfg_restart),
        .cfg_len        (cfg_len),
        .cfg_num_packets(cfg_num_packets),
        .count_data     (count_data),
        .count_valid    (count_valid),
        .count_ready    (count_ready),
        .count_last     (count_last),
        .busy           (busy),
        .done           (done),
        .pkt_count      (pkt_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic build_expected(input logic [7:0] sv, input logic [7:0] st, input bit dn,
                                  input bit rs, input int len, input int np);
        logic [7:0] d;
        d = sv;
        for (int p = 0; p < np; p++) begin
            for (int b = 0; b < len; b++) begin
                exp_q.push_back({(b == len - 1), d});
                if (b == len - 1 && rs) d = sv;
                else                    d = dn ? d - st : d + st;
            end
        end
    endtask

    // bp: random backpressure; mid_start: pulse start with other cfg during RUN;
    // rst_at: assert reset once this many beats have transferred (0 = never).
    task automatic do_run(input logic [7:0] sv, input logic [7:0] st, input bit dn, input bit rs,
                          input logic [7:0] len, input logic [7:0] np, input bit bp,
                          input bit mid_start, input int rst_at);
        int   xfers;
        int   total;
        bit   stalled;
        logic [7:0] st_data;
        logic st_last;
        bit   finished;
        logic [8:0] e;
        exp_q.delete();
        build_expected(sv, st, dn, rs, len, np);
        total    = exp_q.size();
        xfers    = 0;
        stalled  = 0;
        st_data  = '0;
        st_last  = 1'b0;
        finished = 0;

        @(negedge counter_clk);
        cfg_start_value = sv;
        cfg_step        = st;
        cfg_down        = dn;
        cfg_restart     = rs;
        cfg_len         = len;
        cfg_num_packets = np;
        start           = 1'b1;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge counter_clk);
            start = 1'b0;
            // Configuration changes after the latch must be ignored.
            cfg_start_value = 8'hA5;
            cfg_step        = 8'd7;
            cfg_down        = ~dn;
            cfg_restart     = ~rs;
            cfg_len         = 8'd2;
            cfg_num_packets = 8'd9;
            if (mid_start && cyc == 3) start = 1'b1;

            if (rst_at != 0 && xfers == rst_at) begin
                reset = 1'b1;
                @(negedge counter_clk);
                reset = 1'b0;
                check("rst_valid", 32'(count_valid), 0);
                check("rst_last",  32'(count_last),  0);
                check("rst_data",  32'(count_data),  0);
                check("rst_busy",  32'(busy),        0);
                check("rst_done",  32'(done),        0);
                check("rst_pkt",   32'(pkt_count),   0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge counter_clk);
                    check("rst_no_done", 32'(done), 0);
                    check("rst_idle_valid", 32'(count_valid), 0);
                end
                exp_q.delete();
                return;
            end

            count_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;

            check("valid_in_run", 32'(count_valid), 1);
            check("busy_in_run",  32'(busy), 1);
            if (stalled) begin
                check("stall_data", 32'(count_data), 32'(st_data));
                check("stall_last", 32'(count_last), 32'(st_last));
            end
            stalled = !count_ready;
            st_data = count_data;
            st_last = count_last;

            if (count_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(count_data), 32'(e[7:0]));
                    check("beat_last", 32'(count_last), 32'(e[8]));
                end
                xfers++;
                if (xfers == total) begin
                    finished = 1;
                    break;
                end
            end
        end
        count_ready = 1'b1;
        check("run_finished", 32'(finished), 1);

        @(negedge counter_clk);
        check("end_valid", 32'(count_valid), 0);
        check("end_done",  32'(done), 1);
        check("end_busy",  32'(busy), 0);
        check("end_pkt",   32'(pkt_count), 32'(np));
        @(negedge counter_clk);
        check("done_once", 32'(done), 0);
        check("pkt_hold",  32'(pkt_count), 32'(np));
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        cfg_start_value = '0;
        cfg_step        = '0;
        cfg_down        = 1'b0;
        cfg_restart     = 1'b0;
        cfg_len         = '0;
        cfg_num_packets = '0;
        count_ready     = 1'b1;
        repeat (3) @(negedge counter_clk);
        check("reset_valid", 32'(count_valid), 0);
        check("reset_data",  32'(count_data),  0);
        check("reset_last",  32'(count_last),  0);
        check("reset_busy",  32'(busy),        0);
        check("reset_done",  32'(done),        0);
        check("reset_pkt",   32'(pkt_count),   0);
        reset = 1'b0;

        // up, 5,8,11,14
        do_run(8'd5, 8'd3, 1'b0, 1'b0, 8'd4, 8'd1, 1'b0, 1'b0, 0);
        // down with wrap: 2,1,0,255
        do_run(8'd2, 8'd1, 1'b1, 1'b0, 8'd4, 8'd1, 1'b0, 1'b0, 0);
        // restart vs continue across packets
        do_run(8'd10, 8'd1, 1'b0, 1'b1, 8'd3, 8'd2, 1'b0, 1'b0, 0);
        do_run(8'd10, 8'd1, 1'b0, 1'b0, 8'd3, 8'd2, 1'b0, 1'b0, 0);
        // backpressure, same sequences
        do_run(8'd10, 8'd1, 1'b0, 1'b1, 8'd3, 8'd2, 1'b1, 1'b0, 0);
        do_run(8'd250, 8'd9, 1'b0, 1'b0, 8'd5, 8'd3, 1'b1, 1'b0, 0);
        // len=1: every beat is last
        do_run(8'd7, 8'd2, 1'b1, 1'b0, 8'd1, 8'd4, 1'b1, 1'b0, 0);
        // start during RUN has no effect
        do_run(8'd20, 8'd4, 1'b0, 1'b0, 8'd4, 8'd2, 1'b0, 1'b1, 0);

        // len=0: no beat, done within two cycles
        @(negedge counter_clk);
        cfg_len         = 8'd0;
        cfg_num_packets = 8'd3;
        start           = 1'b1;
        @(negedge counter_clk);
        start = 1'b0;
        check("zlen_valid", 32'(count_valid), 0);
        check("zlen_done",  32'(done), 1);
        @(negedge counter_clk);
        check("zlen_done_once", 32'(done), 0);
        check("zlen_valid2",    32'(count_valid), 0);

        // reset at the third beat, then a clean run
        do_run(8'd40, 8'd2, 1'b0, 1'b0, 8'd8, 8'd1, 1'b0, 1'b0, 2);
        do_run(8'd40, 8'd2, 1'b0, 1'b0, 8'd8, 8'd1, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
